// File: rtl/ecg_frame_buffer.sv
// ecg_frame_buffer: ping-pong buffer that packs 8 signed samples into a frame with its base sample
module ecg_frame_buffer #(
  parameter int W    = 16,
  parameter int SEQW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [W-1:0]    b,
  output logic [W-1:0]    x1,
  output logic [W-1:0]    x2,
  output logic [W-1:0]    x3,
  output logic [W-1:0]    x4,
  output logic [W-1:0]    x5,
  output logic [W-1:0]    x6,
  output logic [W-1:0]    x7,
  output logic [W-1:0]    x8,
  output logic [SEQW-1:0] frame_seq,
  output logic            overrun
);
  logic [W-1:0] mem [2][8];
  logic [1:0]   full;
  logic [1:0]   fset;
  logic [1:0]   fclr;
  logic         wb;
  logic         rb;
  logic [2:0]   wi;
  logic [7:0]   ocnt;
  logic         s_acc;
  logic         f_acc;
  logic         stall;
  // s_ready looks only at registered state so the producer never sees frame_ready combinationally
  assign s_ready     = !full[wb];
  assign frame_valid = full[rb];
  assign s_acc       = s_valid && s_ready;
  assign f_acc       = frame_valid && frame_ready;
  assign stall       = s_valid && !s_ready;
  assign fset        = (s_acc && wi == 3'd7) ? (wb ? 2'b10 : 2'b01) : 2'b00;
  assign fclr        = f_acc ? (rb ? 2'b10 : 2'b01) : 2'b00;
  assign x1 = mem[rb][0];
  assign x2 = mem[rb][1];
  assign x3 = mem[rb][2];
  assign x4 = mem[rb][3];
  assign x5 = mem[rb][4];
  assign x6 = mem[rb][5];
  assign x7 = mem[rb][6];
  assign x8 = mem[rb][7];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 8; j++)
          mem[i][j] <= '0;
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wi        <= '0;
      b         <= '0;
      frame_seq <= '0;
      ocnt      <= '0;
      overrun   <= 1'b0;
    end else begin
      if (s_acc) begin
        mem[wb][wi] <= s_data;
        wi          <= wi + 3'd1;
        if (wi == 3'd7) wb <= !wb;
      end
      full <= (full | fset) & ~fclr;
      if (f_acc) begin
        rb        <= !rb;
        b         <= mem[rb][7];
        frame_seq <= frame_seq + SEQW'(1);
      end
      // counter saturates at 255; the 256th consecutive stall cycle latches overrun
      ocnt <= stall ? ocnt + 8'(ocnt != 8'hff) : 8'd0;
      if (stall && ocnt == 8'hff) overrun <= 1'b1;
    end
  end
endmodule
